byte_window_gen: RTL and testbench
==================================

# byte_window_gen

Streaming front end for the Pigasus multiplicative-hash datapath. It accepts a packet as a stream of 64-bit beats and produces, for every beat, the eight overlapping 8-byte windows that start at each byte offset of that beat. Bytes past packet end are zero-padded. The eight windows feed the eight per-byte `mul_hash` lanes. A metadata delay line re-aligns position, start mask and last flag with the hash result.

## Interface
Parameters:
- `HASH_LAT`, 4: pipeline depth of the `mul_hash`+`acc_hash` path in cycles; range 1..16.
- `POS_W`, 16: width of the byte-position counter.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 64: input beat; byte 0 = `[7:0]`, first on wire.
- `s_empty` in 3: count of invalid high bytes; meaningful only with `s_last`.
- `s_valid` in 1: beat valid.
- `s_last` in 1: final beat of packet.
- `s_ready` out 1: beat accepted when `s_valid && s_ready`.
- `win_data` out 512: window i at `[i*64+:64]`; window byte j at `[i*64+j*8+:8]`.
- `win_valid` out 1: windows valid this cycle.
- `win_mask` out 8: bit i = window i starts inside the packet.
- `win_pos` out POS_W: packet byte offset of window 0.
- `win_last` out 1: windows belong to the final beat.
- `hm_valid`, `hm_mask`, `hm_pos`, `hm_last` out 1/8/POS_W/1: win_* metadata aligned with the hash output.

## Operation
- There is no downstream backpressure. The hash pipeline is free-running.
- Window i of beat k covers packet bytes 8k+i .. 8k+i+7, so it needs beat k+1. Beat k is therefore held until beat k+1 arrives, or until the flush cycle.
- FSM states:
  - IDLE: no beat held. `s_ready`=1. An accepted beat is held; go to HOLD, or to FLUSH if `s_last`.
  - HOLD: `s_ready`=1. An accepted beat registers the windows of the held beat, using the new beat as upper bytes. The new beat becomes held. Go to FLUSH if `s_last`, else stay in HOLD.
  - FLUSH: `s_ready`=0. Register windows of the held beat with zero upper bytes. Apply `win_last`=1 and the held `s_empty`. Go to IDLE.
- Zero padding: any window byte whose packet offset is ≥ packet length is forced to 0x00. Packet length is 8·(beats−1) + 8 − `s_empty`.
- `win_mask[i]` = 1 iff offset 8k+i < packet length. It is 0xFF for every non-final beat.
- `win_pos`:
  - Starts at 0 for each packet and adds 8 per emitted beat.
  - Wraps modulo 2^POS_W with no flag.
  - Resets to 0 after `win_last`.
- Outputs are registered. `win_valid` is high for exactly one cycle per input beat.
- Reset value of every output is 0, except `s_ready`, which is 1 in IDLE the cycle after reset release. Reset mid-packet discards the held beat and position, and the FSM goes to IDLE. No `win_last` is emitted for the aborted packet.

## Timing
- A non-final beat k accepted at cycle t is output at cycle t'+1, where t' is the acceptance cycle of beat k+1.
- The final beat accepted at t enters FLUSH at t+1 and is output at t+2. `s_ready` is 0 during cycle t+1.
- Back-to-back packets cost one bubble cycle (FLUSH) on input per packet.
- A single-beat packet accepted at t gives `win_valid` at t+2.
- `hm_*` equals `win_*` delayed exactly HASH_LAT cycles. `hm_*` registers reset to 0.

## Configuration
- `BYTE_WINDOW_GEN_HM_DELAY_EN`:
  - Defined: `hm_*` is driven by the HASH_LAT-deep delay line.
  - Undefined: the delay line is not instantiated; `hm_*` are wired directly to `win_*` (zero delay), for benches that check windows without hash lanes.

## Structure
- Shared package `pigasus_hash_pkg`:
  - constants `WIN_BYTES`=8, `BEAT_BYTES`=8.
  - window typedef (64-bit).
  - meta struct {valid, mask[7:0], pos, last}.
- Sub-module `hash_meta_delay`: parameterised shift register of the meta struct, HASH_LAT stages, synchronous reset to 0.

## Test plan
- Single 8-byte packet, bytes 0x01..0x08, `s_empty`=0:
  - Window 0 = 0x0807060504030201.
  - Window 7 = 0x0000000000000008.
  - `win_mask`=0xFF, `win_last`=1, `win_pos`=0, output 2 cycles after accept.
- Two-beat packet, bytes 0x00..0x0F:
  - First output window 3 = 0x0A09080706050403, `win_pos`=0, `win_last`=0.
  - Second output `win_pos`=8, `win_last`=1.
- Final beat `s_empty`=5 (3 valid bytes):
  - `win_mask`=0x07.
  - Bytes at offsets ≥ length read 0x00 in every window.
- Back-to-back single-beat packets on consecutive cycles: `s_ready` low exactly one cycle after each `s_last`; two `win_last` pulses; no data corruption.
- Assert `rst` while in HOLD mid-packet, then send a new packet: no `win_last` for the aborted packet; new packet `win_pos` starts at 0.
- Macro defined, HASH_LAT=4: `hm_pos`/`hm_mask` equal `win_pos`/`win_mask` exactly 4 cycles later. Feed 8193 non-final beats with POS_W=16: `win_pos` wraps 0xFFF8 → 0x0000.

Source files
------------

// File: rtl/pigasus_hash_pkg.sv
// Shared types and helpers for the Pigasus multiplicative-hash front end:
// window/beat geometry, FSM state encoding and the metadata record that rides beside the hash lanes.
package pigasus_hash_pkg;

  localparam int WIN_BYTES  = 8;
  localparam int BEAT_BYTES = 8;
  localparam int WIN_W      = WIN_BYTES * 8;
  localparam int WINS_W     = BEAT_BYTES * WIN_W;

  // Wide enough for any supported position counter; users keep the low POS_W bits.
  localparam int META_POS_W = 32;

  typedef logic [WIN_W-1:0] window_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [7:0]            mask;
    logic [META_POS_W-1:0] pos;
    logic                  last;
  } meta_t;

  // Zero every byte at or past the end of the packet on its final beat.
  function automatic window_t pad_beat(input window_t data, input logic [2:0] empty);
    window_t r;
    r = data;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      if (j >= BEAT_BYTES - int'(empty)) begin
        r[j*8 +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

  function automatic logic [WINS_W-1:0] build_windows(input window_t lo, input window_t hi);
    logic [2*WIN_W-1:0] cat;
    logic [WINS_W-1:0]  r;
    cat = {hi, lo};
    for (int i = 0; i < BEAT_BYTES; i++) begin
      r[i*WIN_W +: WIN_W] = cat[i*8 +: WIN_W];
    end
    return r;
  endfunction

  function automatic logic [7:0] tail_mask(input logic [2:0] empty);
    logic [7:0] m;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      m[i] = (i < BEAT_BYTES - int'(empty));
    end
    return m;
  endfunction

endpackage

// File: rtl/hash_meta_delay.sv
// Fixed-depth shift register that carries window metadata alongside the hash pipeline
// so position, start mask and last flag line up with the hash result.
module hash_meta_delay
  import pigasus_hash_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  meta_t in_meta,
  output meta_t out_meta
);

  meta_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_meta;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_meta = stage[DEPTH-1];

endmodule

// File: rtl/byte_window_gen.sv
// Beat-to-window expander: emits the eight overlapping 8-byte windows of every input beat.
// Define BYTE_WINDOW_GEN_HM_DELAY_EN to route hm_* through the HASH_LAT-deep metadata delay line.
module byte_window_gen
  import pigasus_hash_pkg::*;
#(
  parameter int HASH_LAT = 4,
  parameter int POS_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       s_data,
  input  logic [2:0]        s_empty,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [511:0]      win_data,
  output logic              win_valid,
  output logic [7:0]        win_mask,
  output logic [POS_W-1:0]  win_pos,
  output logic              win_last,
  output logic              hm_valid,
  output logic [7:0]        hm_mask,
  output logic [POS_W-1:0]  hm_pos,
  output logic              hm_last
);

  if (HASH_LAT < 1 || HASH_LAT > 16) begin : g_bad_hash_lat
    $error("byte_window_gen: HASH_LAT must be in 1..16");
  end

  state_t           state;
  window_t          held_data;
  logic [2:0]       held_empty;
  logic [POS_W-1:0] beat_pos;
  logic             accept;
  window_t          in_beat;

  assign accept  = s_valid && s_ready;
  assign in_beat = s_last ? pad_beat(s_data, s_empty) : s_data;

  // A beat's windows reach into the next beat, so each beat is held until its successor
  // arrives; the final beat is drained in FLUSH with zero upper bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      s_ready    <= 1'b1;
      held_data  <= '0;
      held_empty <= '0;
      beat_pos   <= '0;
      win_data   <= '0;
      win_valid  <= 1'b0;
      win_mask   <= '0;
      win_pos    <= '0;
      win_last   <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            held_data  <= in_beat;
            held_empty <= s_empty;
            state      <= s_last ? ST_FLUSH : ST_HOLD;
            s_ready    <= !s_last;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            win_data   <= build_windows(held_data, in_beat);
            win_valid  <= 1'b1;
            win_mask   <= '1;
            win_pos    <= beat_pos;
            beat_pos   <= beat_pos + POS_W'(BEAT_BYTES);
            held_data  <= in_beat;
            held_empty <= s_empty;
            state      <= s_last ? ST_FLUSH : ST_HOLD;
            s_ready    <= !s_last;
          end
        end
        ST_FLUSH: begin
          win_data  <= build_windows(held_data, '0);
          win_valid <= 1'b1;
          win_mask  <= tail_mask(held_empty);
          win_pos   <= beat_pos;
          win_last  <= 1'b1;
          beat_pos  <= '0;
          state     <= ST_IDLE;
          s_ready   <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef BYTE_WINDOW_GEN_HM_DELAY_EN
  meta_t win_meta;
  meta_t hm_meta;
  logic  unused_meta_pos_hi;

  always_comb begin
    win_meta       = '0;
    win_meta.valid = win_valid;
    win_meta.mask  = win_mask;
    win_meta.pos   = META_POS_W'(win_pos);
    win_meta.last  = win_last;
  end

  hash_meta_delay #(
    .DEPTH (HASH_LAT)
  ) u_meta_delay (
    .clk      (clk),
    .rst      (rst),
    .in_meta  (win_meta),
    .out_meta (hm_meta)
  );

  assign hm_valid           = hm_meta.valid;
  assign hm_mask            = hm_meta.mask;
  assign hm_pos             = hm_meta.pos[POS_W-1:0];
  assign hm_last            = hm_meta.last;
  assign unused_meta_pos_hi = ^(hm_meta.pos >> POS_W);
`else
  assign hm_valid = win_valid;
  assign hm_mask  = win_mask;
  assign hm_pos   = win_pos;
  assign hm_last  = win_last;
`endif

endmodule

// File: tb/tb_byte_window_gen.sv
// Self-checking bench for byte_window_gen: a packet-level byte model predicts every window,
// mask, position and hm_* value per cycle; directed cases pin the model with literal values.
module tb_byte_window_gen;

  localparam int HASH_LAT = 4;
  localparam int POS_W    = 16;
  localparam int HMAX     = 40000;
`ifdef BYTE_WINDOW_GEN_HM_DELAY_EN
  localparam int HM_D = HASH_LAT;
`else
  localparam int HM_D = 0;
`endif

  typedef struct {
    int           cyc;
    logic [511:0] data;
    logic [7:0]   mask;
    logic [15:0]  pos;
    logic         last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [63:0]       s_data = '0;
  logic [2:0]        s_empty = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [511:0]      win_data;
  logic              win_valid;
  logic [7:0]        win_mask;
  logic [POS_W-1:0]  win_pos;
  logic              win_last;
  logic              hm_valid;
  logic [7:0]        hm_mask;
  logic [POS_W-1:0]  hm_pos;
  logic              hm_last;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rst = -100;
  int last_cnt = 0;
  logic m_ready = 1'b1;
  logic [7:0] pkt[$];
  exp_t exp_q[$];
  logic        h_valid [HMAX];
  logic [7:0]  h_mask [HMAX];
  logic [15:0] h_pos [HMAX];
  logic        h_last [HMAX];
  logic [15:0] prev_pos = '0;
  logic [15:0] after_wrap = 16'hDEAD;

  byte_window_gen #(
    .HASH_LAT (HASH_LAT),
    .POS_W    (POS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_empty   (s_empty),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_mask  (win_mask),
    .win_pos   (win_pos),
    .win_last  (win_last),
    .hm_valid  (hm_valid),
    .hm_mask   (hm_mask),
    .hm_pos    (hm_pos),
    .hm_last   (hm_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Window i of beat k holds packet bytes 8k+i .. 8k+i+7, zero past the packet length.
  function automatic exp_t expBeat(input int k, input int len, input logic last);
    exp_t x;
    int off;
    x.cyc = 0;
    x.data = '0;
    x.mask = '0;
    for (int i = 0; i < 8; i++) begin
      x.mask[i] = (8*k + i < len);
      for (int j = 0; j < 8; j++) begin
        off = 8*k + i + j;
        x.data[i*64 + j*8 +: 8] = (off < len) ? pkt[off] : 8'h00;
      end
    end
    x.pos = 16'(8*k);
    x.last = last;
    return x;
  endfunction

  task automatic modelAccept(input logic [63:0] d, input logic [2:0] e, input logic l, input int c);
    int nb;
    int len;
    exp_t x;
    for (int j = 0; j < 8; j++) pkt.push_back(d[j*8 +: 8]);
    nb = pkt.size() / 8;
    len = l ? 8*nb - int'(e) : 8*nb;
    if (nb >= 2) begin
      x = expBeat(nb - 2, len, 1'b0);
      x.cyc = c + 1;
      exp_q.push_back(x);
    end
    if (l) begin
      x = expBeat(nb - 1, len, 1'b1);
      x.cyc = c + 2;
      exp_q.push_back(x);
      pkt.delete();
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    int hc;
    logic hv;
    logic [7:0] hmk;
    logic [15:0] hp;
    logic hl;
    logic acc;
    if (rst) begin
      exp_q.delete();
      pkt.delete();
      m_ready = 1'b1;
      last_rst = cyc;
      if (cyc < HMAX) h_valid[cyc] = 1'b0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checkOutput("win_valid", win_valid, 1'b1);
        checkOutput("win_data", win_data, e.data);
        checkOutput("win_mask", win_mask, e.mask);
        checkOutput("win_pos", win_pos, e.pos);
        checkOutput("win_last", win_last, e.last);
        if (cyc < HMAX) begin
          h_valid[cyc] = 1'b1;
          h_mask[cyc] = e.mask;
          h_pos[cyc] = e.pos;
          h_last[cyc] = e.last;
        end
      end else begin
        checkOutput("win_valid_idle", win_valid, 1'b0);
        if (cyc < HMAX) h_valid[cyc] = 1'b0;
      end
      checkOutput("s_ready", s_ready, m_ready);

      hc = cyc - HM_D;
      hv = 1'b0;
      hmk = '0;
      hp = '0;
      hl = 1'b0;
      if (hc > last_rst && hc >= 0 && hc < HMAX) begin
        hv = h_valid[hc];
        hmk = h_mask[hc];
        hp = h_pos[hc];
        hl = h_last[hc];
      end
      checkOutput("hm_valid", hm_valid, hv);
      if (hv) begin
        checkOutput("hm_mask", hm_mask, hmk);
        checkOutput("hm_pos", hm_pos, hp);
        checkOutput("hm_last", hm_last, hl);
      end

      if (win_valid) begin
        if (prev_pos == 16'hFFF8 && after_wrap == 16'hDEAD) after_wrap = win_pos;
        prev_pos = win_pos;
        if (win_last) last_cnt++;
      end

      acc = s_valid && m_ready;
      if (acc) modelAccept(s_data, s_empty, s_last, cyc);
      m_ready = !(acc && s_last);
    end
  end

  // Presents one beat and holds it until the DUT takes it; returns the stall cycles.
  task automatic applyStimulus(input logic [63:0] d, input logic [2:0] e, input logic l,
                               output int waited);
    waited = 0;
    s_data = d;
    s_empty = e;
    s_last = l;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      bad++;
      total++;
      $display("[TB] FAIL accept_timeout: s_ready stayed 0 for %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic waitWin(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!win_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!win_valid) begin
      bad++;
      total++;
      $display("[TB] FAIL %s_timeout: win_valid 0 after %0d cycles, required 1", name, n);
    end
  endtask

  initial begin
    int w;
    int w2;
    int lc0;
    int nb;
    int gap;
    logic lst;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_win_valid", win_valid, 1'b0);
    checkOutput("rst_win_data", win_data, 512'd0);
    checkOutput("rst_win_mask", win_mask, 8'h00);
    checkOutput("rst_win_pos", win_pos, 16'h0000);
    checkOutput("rst_win_last", win_last, 1'b0);
    checkOutput("rst_hm_valid", hm_valid, 1'b0);
    checkOutput("rst_s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] single 8-byte packet");
    applyStimulus(64'h0807060504030201, 3'd0, 1'b1, w);
    @(negedge clk);
    checkOutput("t1_ready_flush", s_ready, 1'b0);
    @(negedge clk);
    checkOutput("t1_valid_t2", win_valid, 1'b1);
    checkOutput("t1_win0", win_data[63:0], 64'h0807060504030201);
    checkOutput("t1_win7", win_data[511:448], 64'h0000000000000008);
    checkOutput("t1_mask", win_mask, 8'hFF);
    checkOutput("t1_last", win_last, 1'b1);
    checkOutput("t1_pos", win_pos, 16'h0000);
    @(posedge clk);
    #1;

    $display("[TB] two-beat packet");
    applyStimulus(64'h0706050403020100, 3'd0, 1'b0, w);
    applyStimulus(64'h0F0E0D0C0B0A0908, 3'd0, 1'b1, w);
    @(negedge clk);
    checkOutput("t2_valid0", win_valid, 1'b1);
    checkOutput("t2_win3", win_data[255:192], 64'h0A09080706050403);
    checkOutput("t2_pos0", win_pos, 16'h0000);
    checkOutput("t2_last0", win_last, 1'b0);
    @(negedge clk);
    checkOutput("t2_valid1", win_valid, 1'b1);
    checkOutput("t2_pos1", win_pos, 16'h0008);
    checkOutput("t2_last1", win_last, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] final beat with s_empty=5");
    applyStimulus(64'hFFEEDDCCBBAA9988, 3'd5, 1'b1, w);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t3_mask", win_mask, 8'h07);
    checkOutput("t3_win0", win_data[63:0], 64'h0000000000AA9988);
    checkOutput("t3_win2", win_data[191:128], 64'h00000000000000AA);
    checkOutput("t3_win3", win_data[255:192], 64'h0);
    @(posedge clk);
    #1;

    $display("[TB] back-to-back single-beat packets");
    lc0 = last_cnt;
    applyStimulus(64'h1111111111111111, 3'd0, 1'b1, w);
    applyStimulus(64'h2222222222222222, 3'd2, 1'b1, w2);
    checkOutput("b2b_first_wait", w, 0);
    checkOutput("b2b_bubble", w2, 1);
    repeat (4) @(negedge clk);
    checkOutput("b2b_last_pulses", last_cnt - lc0, 2);
    @(posedge clk);
    #1;

    $display("[TB] reset while holding a beat");
    applyStimulus(64'hA5A5A5A5A5A5A5A5, 3'd0, 1'b0, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lc0 = last_cnt;
    applyStimulus(64'h0102030405060708, 3'd0, 1'b1, w);
    waitWin("t5");
    checkOutput("t5_pos", win_pos, 16'h0000);
    checkOutput("t5_last", win_last, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("t5_last_pulses", last_cnt - lc0, 1);
    @(posedge clk);
    #1;

    $display("[TB] position wrap over 8194 beats");
    for (int b = 0; b < 8194; b++) begin
      applyStimulus({$urandom, $urandom}, 3'($urandom_range(0, 7)), b == 8193, w);
    end
    repeat (4) @(negedge clk);
    checkOutput("wrap_pos", after_wrap, 16'h0000);
    @(posedge clk);
    #1;

    $display("[TB] random packets");
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        lst = (b == nb - 1);
        applyStimulus({$urandom, $urandom}, 3'($urandom_range(0, 7)), lst, w);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (HASH_LAT + 8) @(negedge clk);
    checkOutput("drain_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
